rssb_mem_responder: RTL and testbench

Memory-side responder for the RSSB core's data/instruction bus. Accepts one request at a time from the core's control sequencer over a valid/ready handshake and serves it from an internal word RAM after a programmable number of wait states. Maps two addresses to I/O: one to an input port with stall and one to an output port. Sits between the core datapath and the program/data store, and gives the core a real memory latency to sequence against.

---
 rtl/rssb_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_rssb_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rssb_mem_responder.sv
// Memory-side responder for the RSSB core bus: one request at a time, served from
// an internal word RAM after WAIT_CYCLES wait states, with one input and one output port.
module rssb_mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int IN_ADDR     = 3,
    parameter int OUT_ADDR    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    // state     | meaning
    // S_IDLE    | ready for a request; latch it on req_valid
    // S_WAIT    | counting down wait states
    // S_INSTALL | read of the input port, stalled until in_valid
    // S_RESP    | one-cycle response / write acknowledge

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_W-1:0] IN_A      = ADDR_W'(IN_ADDR);
    localparam logic [ADDR_W-1:0] OUT_A     = ADDR_W'(OUT_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_INSTALL = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_in_rd;
    logic              cur_in_range;
    logic [IDX_W-1:0]  cur_idx;
    logic              enter_resp;

    // With zero wait states the request goes straight from IDLE to INSTALL/RESP,
    // before the latches hold it, so the live bus values are used there.
    always_comb begin
        cur_we       = (state_q == S_IDLE) ? req_we    : lat_we;
        cur_addr     = (state_q == S_IDLE) ? req_addr  : lat_addr;
        cur_wdata    = (state_q == S_IDLE) ? req_wdata : lat_wdata;
        cur_in_rd    = !cur_we && (cur_addr == IN_A);
        cur_in_range = {1'b0, cur_addr} < DEPTH_LIM;
        cur_idx      = cur_addr[IDX_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                    end else if (cur_in_rd) begin
                        state_d = S_INSTALL;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = cur_in_rd ? S_INSTALL : S_RESP;
                end
            end
            S_INSTALL: begin
                if (in_valid) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE) && !rst;
        rsp_valid = (state_q == S_RESP);
        in_ready  = (state_q == S_INSTALL) && in_valid;
        out_valid = (state_q == S_RESP) && lat_we && (lat_addr == OUT_A);
    end

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt_q     <= '0;
            rsp_rdata <= '0;
            out_data  <= '0;
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt_q     <= CNT_LOAD;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (enter_resp) begin
                if (cur_we) begin
                    rsp_rdata <= '0;
                    if (cur_addr == OUT_A) begin
                        out_data <= cur_wdata;
                    end
                end else if (cur_in_rd) begin
                    rsp_rdata <= in_data;
                end else if (cur_in_range) begin
                    rsp_rdata <= mem[cur_idx];
                end else begin
                    rsp_rdata <= '0;
                end
            end
        end
    end

    // RAM contents survive reset; writes land only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && cur_in_range) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

endmodule

// File: tb/tb_rssb_mem_responder.sv
// Directed bench for rssb_mem_responder: one instance with one wait state and full
// depth, one with zero wait states and DEPTH=16.
module tb_rssb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic       req_valid_a = 0, req_we_a = 0, in_valid_a = 0;
    logic [7:0] req_addr_a = 0, req_wdata_a = 0, in_data_a = 0;
    logic       req_ready_a, rsp_valid_a, in_ready_a, out_valid_a;
    logic [7:0] rsp_rdata_a, out_data_a;

    logic       req_valid_b = 0, req_we_b = 0, in_valid_b = 0;
    logic [7:0] req_addr_b = 0, req_wdata_b = 0, in_data_b = 0;
    logic       req_ready_b, rsp_valid_b, in_ready_b, out_valid_b;
    logic [7:0] rsp_rdata_b, out_data_b;

    always #5 clk = ~clk;

    rssb_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(1),
                         .IN_ADDR(3), .OUT_ADDR(4)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a)
    );

    rssb_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(0),
                         .IN_ADDR(3), .OUT_ADDR(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b)
    );

    // Issue one request and wait for its response. lat counts falling edges after
    // the acceptance edge until rsp_valid is seen; -1 means it never came.
    task automatic txn_a(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         output logic acc_rdy, output int lat, output logic [7:0] rdata,
                         output logic rdy, output logic ov, output logic [7:0] od);
        @(negedge clk);
        acc_rdy     = req_ready_a;
        req_valid_a = 1'b1;
        req_we_a    = we;
        req_addr_a  = addr;
        req_wdata_a = wdata;
        @(negedge clk);
        req_valid_a = 1'b0;
        lat = -1; rdata = 'x; rdy = 'x; ov = 'x; od = 'x;
        for (int n = 1; n <= 30; n++) begin
            if (rsp_valid_a === 1'b1) begin
                lat = n; rdata = rsp_rdata_a; rdy = req_ready_a;
                ov = out_valid_a; od = out_data_a;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic txn_b(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         output logic acc_rdy, output int lat, output logic [7:0] rdata,
                         output logic rdy, output logic ov, output logic [7:0] od);
        @(negedge clk);
        acc_rdy     = req_ready_b;
        req_valid_b = 1'b1;
        req_we_b    = we;
        req_addr_b  = addr;
        req_wdata_b = wdata;
        @(negedge clk);
        req_valid_b = 1'b0;
        lat = -1; rdata = 'x; rdy = 'x; ov = 'x; od = 'x;
        for (int n = 1; n <= 30; n++) begin
            if (rsp_valid_b === 1'b1) begin
                lat = n; rdata = rsp_rdata_b; rdy = req_ready_b;
                ov = out_valid_b; od = out_data_b;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic acc, rdy, ov;
        int lat;
        logic [7:0] rd, od;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready_during_rst: got %b expected 0", req_ready_a); end
        rst = 1'b0;
        #1;
        checks++; if ({req_ready_a, rsp_valid_a, in_ready_a, out_valid_a} !== 4'b1000) begin errors++; $display("FAIL reset_ctrl_a: got %b expected 1000", {req_ready_a, rsp_valid_a, in_ready_a, out_valid_a}); end
        checks++; if ({rsp_rdata_a, out_data_a} !== 16'h0000) begin errors++; $display("FAIL reset_data_a: got %h expected 0000", {rsp_rdata_a, out_data_a}); end
        checks++; if ({req_ready_b, rsp_valid_b, in_ready_b, out_valid_b} !== 4'b1000) begin errors++; $display("FAIL reset_ctrl_b: got %b expected 1000", {req_ready_b, rsp_valid_b, in_ready_b, out_valid_b}); end

        // Seed OUT_ADDR, then abort a second write to it while in WAIT.
        txn_a(1'b1, 8'd4, 8'h21, acc, lat, rd, rdy, ov, od);
        checks++; if (od !== 8'h21) begin errors++; $display("FAIL reset_seed_out: got %h expected 21", od); end
        @(negedge clk);
        req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 8'd4; req_wdata_a = 8'hEE;
        @(negedge clk);
        req_valid_a = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready_a !== 1'b1) begin errors++; $display("FAIL reset_mid_wait_ready: got %b expected 1", req_ready_a); end
        checks++; if (out_data_a !== 8'h00) begin errors++; $display("FAIL reset_mid_wait_out_data: got %h expected 00", out_data_a); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({rsp_valid_a, out_valid_a} !== 2'b00) begin errors++; $display("FAIL reset_no_rsp cycle %0d: got %b expected 00", i, {rsp_valid_a, out_valid_a}); end
        end
        txn_a(1'b0, 8'd4, 8'h00, acc, lat, rd, rdy, ov, od);
        checks++; if (rd !== 8'h21) begin errors++; $display("FAIL reset_dropped_write: got %h expected 21", rd); end
    endtask

    task automatic test_wait1();
        logic acc, rdy, ov;
        int lat;
        logic [7:0] rd, od;
        txn_a(1'b1, 8'd10, 8'h5A, acc, lat, rd, rdy, ov, od);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL w1_accept_ready: got %b expected 1", acc); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL w1_write_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL w1_write_rdata: got %h expected 00", rd); end
        txn_a(1'b0, 8'd10, 8'h00, acc, lat, rd, rdy, ov, od);
        checks++; if (lat !== 2) begin errors++; $display("FAIL w1_read_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL w1_read_rdata: got %h expected 5a", rd); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL w1_ready_in_resp: got %b expected 0", rdy); end
        @(negedge clk);
        checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL w1_rsp_pulse: got %b expected 0", rsp_valid_a); end
        checks++; if (rsp_rdata_a !== 8'h5A) begin errors++; $display("FAIL w1_rdata_hold: got %h expected 5a", rsp_rdata_a); end
        txn_a(1'b1, 8'd11, 8'hA5, acc, lat, rd, rdy, ov, od);
        txn_a(1'b0, 8'd11, 8'h00, acc, lat, rd, rdy, ov, od);
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL w1_read_11: got %h expected a5", rd); end
        txn_a(1'b0, 8'd10, 8'h00, acc, lat, rd, rdy, ov, od);
        checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL w1_read_10_again: got %h expected 5a", rd); end
    endtask

    task automatic test_install();
        @(negedge clk);
        req_valid_a = 1'b1; req_we_a = 1'b0; req_addr_a = 8'd3; req_wdata_a = 8'h00;
        in_valid_a = 1'b0; in_data_a = 8'h00;
        @(negedge clk);
        req_valid_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({in_ready_a, rsp_valid_a} !== 2'b00) begin errors++; $display("FAIL install_stall cycle %0d: got %b expected 00", i, {in_ready_a, rsp_valid_a}); end
            @(negedge clk);
        end
        in_data_a = 8'h7F; in_valid_a = 1'b1;
        #1;
        checks++; if ({in_ready_a, rsp_valid_a} !== 2'b10) begin errors++; $display("FAIL install_in_ready: got %b expected 10", {in_ready_a, rsp_valid_a}); end
        @(negedge clk);
        checks++; if ({in_ready_a, rsp_valid_a} !== 2'b01) begin errors++; $display("FAIL install_resp: got %b expected 01", {in_ready_a, rsp_valid_a}); end
        checks++; if (rsp_rdata_a !== 8'h7F) begin errors++; $display("FAIL install_rdata: got %h expected 7f", rsp_rdata_a); end
        in_valid_a = 1'b0; in_data_a = 8'h00;
        @(negedge clk);
        checks++; if ({in_ready_a, rsp_valid_a, req_ready_a} !== 3'b001) begin errors++; $display("FAIL install_back_idle: got %b expected 001", {in_ready_a, rsp_valid_a, req_ready_a}); end
    endtask

    task automatic test_out_port();
        logic acc, rdy, ov;
        int lat;
        logic [7:0] rd, od;
        txn_a(1'b1, 8'd4, 8'hC3, acc, lat, rd, rdy, ov, od);
        checks++; if ({ov, od} !== 9'h1C3) begin errors++; $display("FAIL out_write_pulse: got %h expected 1c3", {ov, od}); end
        @(negedge clk);
        checks++; if ({out_valid_a, out_data_a} !== 9'h0C3) begin errors++; $display("FAIL out_hold: got %h expected 0c3", {out_valid_a, out_data_a}); end
        txn_a(1'b0, 8'd4, 8'h00, acc, lat, rd, rdy, ov, od);
        checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL out_readback: got %h expected c3", rd); end
        checks++; if ({ov, od} !== 9'h0C3) begin errors++; $display("FAIL out_read_no_pulse: got %h expected 0c3", {ov, od}); end
        txn_a(1'b1, 8'd3, 8'h66, acc, lat, rd, rdy, ov, od);
        checks++; if (lat !== 2) begin errors++; $display("FAIL in_addr_write_no_stall: got %0d expected 2", lat); end
        checks++; if ({ov, od} !== 9'h0C3) begin errors++; $display("FAIL in_addr_write_out: got %h expected 0c3", {ov, od}); end
    endtask

    task automatic test_back_to_back();
        logic acc, rdy, ov;
        int lat;
        logic [7:0] rd, od;
        txn_b(1'b1, 8'd10, 8'h3C, acc, lat, rd, rdy, ov, od);
        checks++; if (lat !== 1) begin errors++; $display("FAIL w0_write_latency: got %0d expected 1", lat); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL w0_ready_in_resp: got %b expected 0", rdy); end
        txn_b(1'b0, 8'd10, 8'h00, acc, lat, rd, rdy, ov, od);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL w0_idle_gap_ready: got %b expected 1", acc); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL w0_read_latency: got %0d expected 1", lat); end
        checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL w0_read_rdata: got %h expected 3c", rd); end
        in_data_b = 8'h42; in_valid_b = 1'b1;
        txn_b(1'b0, 8'd3, 8'h00, acc, lat, rd, rdy, ov, od);
        in_valid_b = 1'b0;
        checks++; if (lat !== 2) begin errors++; $display("FAIL w0_install_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 8'h42) begin errors++; $display("FAIL w0_install_rdata: got %h expected 42", rd); end
    endtask

    task automatic test_depth();
        logic acc, rdy, ov;
        int lat;
        logic [7:0] rd, od;
        txn_b(1'b1, 8'd8, 8'h77, acc, lat, rd, rdy, ov, od);
        txn_b(1'b1, 8'd200, 8'h11, acc, lat, rd, rdy, ov, od);
        checks++; if (lat !== 1) begin errors++; $display("FAIL depth_write_acked: got %0d expected 1", lat); end
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL depth_write_rdata: got %h expected 00", rd); end
        txn_b(1'b0, 8'd8, 8'h00, acc, lat, rd, rdy, ov, od);
        checks++; if (rd !== 8'h77) begin errors++; $display("FAIL depth_no_alias: got %h expected 77", rd); end
        txn_b(1'b0, 8'd200, 8'h00, acc, lat, rd, rdy, ov, od);
        checks++; if (lat !== 1) begin errors++; $display("FAIL depth_read_latency: got %0d expected 1", lat); end
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL depth_read_oob: got %h expected 00", rd); end
    endtask

    initial begin
        test_reset();
        test_wait1();
        test_install();
        test_out_port();
        test_back_to_back();
        test_depth();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
